// File: rtl/pll_sup_pkg.sv
// +--------------------------------------------------------------------------+
// | pll_sup_pkg : shared types and helpers for the PLL supervisor            |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    READY     = 3'd3,
    PH_SETUP  = 3'd4,
    PH_PULSE  = 3'd5,
    PH_HOLD   = 3'd6,
    FAULT     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    CH_CLKOP  = 2'd0,
    CH_CLKOS  = 2'd1,
    CH_CLKOS2 = 2'd2,
    CH_CLKOS3 = 2'd3
  } ch_e;

  // Width able to hold the largest reload value of the shared timer.
  function automatic int timer_width(input int a, input int b, input int c,
                                     input int d, input int e, input int f);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +--------------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer for a single asynchronous bit           |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_supervisor.sv
// +--------------------------------------------------------------------------+
// | pll_supervisor : EHXPLLL reset/lock supervision and phase-step sequencer |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module pll_supervisor
  import pll_sup_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int PH_W         = 8,
  parameter int RST_CYC      = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STABLE_CYC   = 4096,
  parameter int MAX_RETRIES  = 3,
  parameter int SETUP_CYC    = 2,
  parameter int STEP_CYC     = 2,
  parameter int HOLD_CYC     = 4
) (
  input  logic                 clkin,
  input  logic                 resetn,
  input  logic                 pll_lock,
  output logic                 pll_rst,
  output logic [1:0]           pll_phasesel,
  output logic                 pll_phasedir,
  output logic                 pll_phasestep,
  output logic                 pll_phaseloadreg,
  input  logic                 ph_req,
  input  logic [1:0]           ph_ch,
  input  logic                 ph_dir,
  output logic                 ph_ack,
  output logic                 ph_err,
  input  logic                 clear_fault,
  output logic                 ready,
  output logic                 fault,
  output logic [1:0]           retry_cnt,
  output logic [N_CH*PH_W-1:0] phase_pos
);

  localparam int TW = timer_width(RST_CYC, LOCK_TIMEOUT, STABLE_CYC,
                                  SETUP_CYC, STEP_CYC, HOLD_CYC);

  localparam logic [TW-1:0] T_RST   = TW'(RST_CYC - 1);
  localparam logic [TW-1:0] T_LOCK  = TW'(LOCK_TIMEOUT - 1);
  // STABLE is entered on the cycle lock_s is first seen, so the window
  // spans one extra sample; this keeps first READY at RST+2+STABLE cycles.
  localparam logic [TW-1:0] T_STAB  = TW'(STABLE_CYC);
  localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] T_STEP  = TW'(STEP_CYC - 1);
  localparam logic [TW-1:0] T_HOLD  = TW'(HOLD_CYC - 1);
  localparam logic [1:0]    MAX_R   = 2'(MAX_RETRIES);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk   (clkin),
    .rst_n (resetn),
    .d     (pll_lock),
    .q     (lock_s)
  );

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pll_rst_q, pll_rst_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;
  logic            step_q, step_d;
  logic [1:0]      sel_q, sel_d;
  logic            dir_q, dir_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [1:0]      retry_q, retry_d;
  logic            armed_q, armed_d;
  logic [PH_W-1:0] pos_q [N_CH];
  logic [PH_W-1:0] pos_d [N_CH];
  logic            t_zero;
  logic [TW-1:0]   t_dec;

  assign t_zero = (timer_q == '0);
  assign t_dec  = timer_q - TW'(1);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pll_rst_d = pll_rst_q;
    ready_d   = ready_q;
    fault_d   = fault_q;
    step_d    = step_q;
    sel_d     = sel_q;
    dir_d     = dir_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    retry_d   = retry_q;
    armed_d   = ph_req ? armed_q : 1'b1;
    for (int i = 0; i < N_CH; i++) pos_d[i] = pos_q[i];

    if ((state_q == READY || state_q == PH_SETUP || state_q == PH_PULSE ||
         state_q == PH_HOLD) && !lock_s) begin
      // PLL reset restores static phase, so the position counters follow.
      state_d   = RESET_PLL;
      timer_d   = T_RST;
      pll_rst_d = 1'b1;
      ready_d   = 1'b0;
      step_d    = 1'b0;
      for (int i = 0; i < N_CH; i++) pos_d[i] = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (t_zero) begin
            state_d   = WAIT_LOCK;
            timer_d   = T_LOCK;
            pll_rst_d = 1'b0;
          end else begin
            timer_d = t_dec;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            timer_d = T_STAB;
          end else if (t_zero) begin
            retry_d   = retry_q + 2'd1;
            timer_d   = T_RST;
            pll_rst_d = 1'b1;
            if (retry_q + 2'd1 == MAX_R) begin
              state_d = FAULT;
              fault_d = 1'b1;
            end else begin
              state_d = RESET_PLL;
            end
          end else begin
            timer_d = t_dec;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d   = RESET_PLL;
            timer_d   = T_RST;
            pll_rst_d = 1'b1;
          end else if (t_zero) begin
            state_d = READY;
            ready_d = 1'b1;
            retry_d = 2'd0;
          end else begin
            timer_d = t_dec;
          end
        end
        READY: begin
          if (ph_req && armed_q) begin
            sel_d   = ph_ch;
            dir_d   = ph_dir;
            armed_d = 1'b0;
            if (int'(ph_ch) >= N_CH) begin
              ack_d = 1'b1;
              err_d = 1'b1;
            end else begin
              state_d = PH_SETUP;
              timer_d = T_SETUP;
            end
          end
        end
        PH_SETUP: begin
          if (t_zero) begin
            state_d = PH_PULSE;
            timer_d = T_STEP;
            step_d  = 1'b1;
          end else begin
            timer_d = t_dec;
          end
        end
        PH_PULSE: begin
          if (t_zero) begin
            state_d = PH_HOLD;
            timer_d = T_HOLD;
            step_d  = 1'b0;
          end else begin
            timer_d = t_dec;
          end
        end
        PH_HOLD: begin
          if (t_zero) begin
            state_d = READY;
            ack_d   = 1'b1;
            for (int i = 0; i < N_CH; i++) begin
              if (sel_q == 2'(i))
                pos_d[i] = dir_q ? pos_q[i] + PH_W'(1) : pos_q[i] - PH_W'(1);
            end
          end else begin
            timer_d = t_dec;
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state_d = RESET_PLL;
            timer_d = T_RST;
            fault_d = 1'b0;
            retry_d = 2'd0;
          end
        end
        default: begin
          state_d   = RESET_PLL;
          timer_d   = T_RST;
          pll_rst_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RESET_PLL;
      timer_q   <= T_RST;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      step_q    <= 1'b0;
      sel_q     <= CH_CLKOP;
      dir_q     <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      retry_q   <= 2'd0;
      armed_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) pos_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      step_q    <= step_d;
      sel_q     <= sel_d;
      dir_q     <= dir_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      retry_q   <= retry_d;
      armed_q   <= armed_d;
      for (int i = 0; i < N_CH; i++) pos_q[i] <= pos_d[i];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_pos
    assign phase_pos[g*PH_W +: PH_W] = pos_q[g];
  end

  assign pll_rst          = pll_rst_q;
  assign pll_phasesel     = sel_q;
  assign pll_phasedir     = dir_q;
  assign pll_phasestep    = step_q;
  assign pll_phaseloadreg = 1'b0;
  assign ph_ack           = ack_q;
  assign ph_err           = err_q;
  assign ready            = ready_q;
  assign fault            = fault_q;
  assign retry_cnt        = retry_q;

endmodule

`default_nettype wire
